// File: rtl/ctrl_pkg.sv
// Shared controller definitions: sequencer state encoding, error codes and default opcodes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  localparam logic [3:0] NOP_OP_DEF = 4'h0;

endpackage

// File: rtl/exec_sequencer.sv
// Sequences one instruction through operand read, execute, flag check and writeback.
// Six states, one cycle each; start is only honoured in IDLE, abort only in READ/EXEC/CHECK.
module exec_sequencer
  import ctrl_pkg::*;
#(
  parameter int         W          = 4,
  parameter int         AW         = 4,
  parameter logic [3:0] NOP_OP     = NOP_OP_DEF,
  parameter bit         WB_ON_FLOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    op,
  input  logic [AW-1:0] rd1,
  input  logic [AW-1:0] rd2,
  input  logic [AW-1:0] wr,
  input  logic [W-1:0]  rf_rdata_a,
  input  logic [W-1:0]  rf_rdata_b,
  input  logic [W-1:0]  alu_result,
  input  logic          overflow,
  input  logic          underflow,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata,
  output logic [3:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [1:0]    err_code,
  output logic [7:0]    exec_cnt
);

  state_t        state, state_nxt;
  logic [3:0]    op_q;
  logic [AW-1:0] rd1_q, rd2_q, wr_q;
  logic          wb_allowed;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  state_nxt = abort ? ST_IDLE : ST_EXEC;
      ST_EXEC:  state_nxt = abort ? ST_IDLE : ST_CHECK;
      ST_CHECK: state_nxt = abort ? ST_IDLE : ST_WB;
      ST_WB:    state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Writes and done are also masked by rst so a reset sampled in WB/DONE has no side effect.
  assign wb_allowed = (op_q != NOP_OP) && (WB_ON_FLOW || (err_code == ERR_NONE));

  always_comb begin
    busy  = (state != ST_IDLE);
    rf_we = 1'b0;
    done  = 1'b0;
    if (!rst) begin
      rf_we = (state == ST_WB) && wb_allowed;
      done  = (state == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      wr_q     <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      result   <= '0;
      err_code <= ERR_NONE;
      exec_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op;
            rd1_q    <= rd1;
            rd2_q    <= rd2;
            wr_q     <= wr;
            err_code <= ERR_NONE;
          end
        end
        ST_EXEC: begin
          alu_a <= rf_rdata_a;
          alu_b <= rf_rdata_b;
        end
        ST_CHECK: begin
          if (!abort) begin
            result <= alu_result;
            if (overflow)       err_code <= ERR_OVF;
            else if (underflow) err_code <= ERR_UNF;
            else                err_code <= ERR_NONE;
          end
        end
        ST_DONE: begin
          if (exec_cnt != 8'hFF) exec_cnt <= exec_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign rf_raddr_a = rd1_q;
  assign rf_raddr_b = rd2_q;
  assign alu_op     = op_q;
  assign rf_waddr   = wr_q;
  assign rf_wdata   = result;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench: register file and signed 4-bit ALU models around exec_sequencer.
module tb_exec_sequencer;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] op, rd1, rd2, wr;
  logic [3:0] rf_rdata_a, rf_rdata_b, alu_result;
  logic       overflow, underflow;
  logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_op, alu_a, alu_b, result;
  logic       rf_we, busy, done;
  logic [1:0] err_code;
  logic [7:0] exec_cnt;

  logic       force_ovf, force_unf;
  logic [3:0] mem [16];

  int checks = 0;
  int errors = 0;

  // Per-instruction observations, cycle numbers relative to the accepting edge T.
  int         we_cnt, we_cyc, done_cnt, done_cyc, busy_bad;
  logic [3:0] waddr_s, wdata_s, raddr_a_s, raddr_b_s;
  logic [1:0] err_t1;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
    .rd1(rd1), .rd2(rd2), .wr(wr),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_result(alu_result), .overflow(overflow), .underflow(underflow),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .done(done), .result(result),
    .err_code(err_code), .exec_cnt(exec_cnt)
  );

  always @(posedge clk) begin
    rf_rdata_a <= mem[rf_raddr_a];
    rf_rdata_b <= mem[rf_raddr_b];
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  always_comb begin
    int ia, ib, ir;
    ia = int'($signed(alu_a));
    ib = int'($signed(alu_b));
    ir = 0;
    if (alu_op == OP_ADD)      ir = ia + ib;
    else if (alu_op == OP_SUB) ir = ia - ib;
    alu_result = ir[3:0];
    overflow   = (ir > 7) || force_ovf;
    underflow  = (ir < -8) || force_unf;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe(input int k);
    if (rf_we) begin
      we_cnt++;
      we_cyc  = k;
      waddr_s = rf_waddr;
      wdata_s = rf_wdata;
    end
    if (done) begin
      done_cnt++;
      done_cyc = k;
    end
    if (busy !== (k >= 1 && k <= 5)) busy_bad++;
    if (k == 1) begin
      raddr_a_s = rf_raddr_a;
      raddr_b_s = rf_raddr_b;
      err_t1    = err_code;
    end
  endtask

  // Accepts a start at edge T, then samples cycles T+1..T+6; returns in cycle T+6 (IDLE).
  task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] w);
    we_cnt = 0; we_cyc = -1; done_cnt = 0; done_cyc = -1; busy_bad = 0;
    @(negedge clk);
    op = o; rd1 = a; rd2 = b; wr = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 4'hF; rd1 = 4'hF; rd2 = 4'hF; wr = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      observe(k);
      @(posedge clk); #1;
    end
    observe(6);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[1] = 4'd3; mem[2] = 4'd2; mem[3] = 4'h8; mem[4] = 4'd1; mem[7] = 4'd7;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    op = '0; rd1 = '0; rd2 = '0; wr = '0;
    force_ovf = 1'b0; force_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_we", rf_we, 0);
    check("reset_result", result, 0);
    check("reset_err", err_code, 0);
    check("reset_cnt", exec_cnt, 0);
    check("reset_alu_ab", {alu_a, alu_b, alu_op}, 0);
    check("reset_addr", {rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 3 + 2 into R5
    issue(OP_ADD, 4'd1, 4'd2, 4'd5);
    check("add_raddr", {raddr_a_s, raddr_b_s}, 8'h12);
    check("add_we_cyc", we_cyc, 4);
    check("add_we_cnt", we_cnt, 1);
    check("add_waddr", waddr_s, 5);
    check("add_wdata", wdata_s, 5);
    check("add_done_cyc", done_cyc, 5);
    check("add_done_cnt", done_cnt, 1);
    check("add_busy", busy_bad, 0);
    check("add_err", err_code, 0);
    check("add_cnt", exec_cnt, 1);
    check("add_mem5", mem[5], 5);
    check("add_alu_ab", {alu_a, alu_b}, 8'h32);

    // 7 + 7 overflows signed 4-bit: write suppressed
    issue(OP_ADD, 4'd7, 4'd7, 4'd9);
    check("ovf_we_cnt", we_cnt, 0);
    check("ovf_err", err_code, 1);
    check("ovf_result", result, 4'hE);
    check("ovf_done_cyc", done_cyc, 5);
    check("ovf_mem9", mem[9], 0);
    check("ovf_cnt", exec_cnt, 2);

    // -8 - 1 underflows
    issue(OP_SUB, 4'd3, 4'd4, 4'd10);
    check("unf_err_cleared", err_t1, 0);
    check("unf_err", err_code, 2);
    check("unf_we_cnt", we_cnt, 0);
    check("unf_result", result, 4'h7);

    // Both flags forced: overflow wins
    force_ovf = 1'b1; force_unf = 1'b1;
    issue(OP_ADD, 4'd1, 4'd2, 4'd6);
    force_ovf = 1'b0; force_unf = 1'b0;
    check("both_err", err_code, 1);
    check("both_we_cnt", we_cnt, 0);
    check("both_mem6", mem[6], 0);

    // NOP completes without writeback
    issue(OP_NOP, 4'd1, 4'd2, 4'd11);
    check("nop_we_cnt", we_cnt, 0);
    check("nop_done_cyc", done_cyc, 5);
    check("nop_cnt", exec_cnt, 5);
    check("nop_err", err_code, 0);

    // Start re-pulsed in EXEC, abort in CHECK
    we_cnt = 0; done_cnt = 0; busy_bad = 0;
    @(negedge clk);
    op = OP_ADD; rd1 = 4'd7; rd2 = 4'd1; wr = 4'd12; start = 1'b1;
    @(posedge clk); #1;                 // cycle T+1 READ
    start = 1'b0;
    @(posedge clk); #1;                 // cycle T+2 EXEC
    start = 1'b1; op = OP_ADD; rd1 = 4'd1; rd2 = 4'd2; wr = 4'd13;
    @(posedge clk); #1;                 // cycle T+3 CHECK
    start = 1'b0; abort = 1'b1;
    check("abort_busy_in_check", busy, 1);
    @(posedge clk); #1;                 // cycle T+4
    abort = 1'b0;
    for (int k = 4; k <= 9; k++) begin
      if (rf_we) we_cnt++;
      if (done) done_cnt++;
      if (busy) busy_bad++;
      @(posedge clk); #1;
    end
    check("abort_we_cnt", we_cnt, 0);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_idle", busy_bad, 0);
    check("abort_result", result, 0);
    check("abort_err", err_code, 0);
    check("abort_cnt", exec_cnt, 5);
    check("abort_mem12_13", {mem[12], mem[13]}, 0);

    // rst asserted during WB
    @(negedge clk);
    op = OP_ADD; rd1 = 4'd1; rd2 = 4'd2; wr = 4'd14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;                                 // cycle T+4 WB
    rst = 1'b1;
    #1;
    check("rstwb_we", rf_we, 0);
    @(posedge clk); #1;
    check("rstwb_mem14", mem[14], 0);
    check("rstwb_ctrl", {busy, done, rf_we}, 0);
    check("rstwb_data", {result, alu_a, alu_b, alu_op}, 0);
    check("rstwb_err_cnt", {err_code, exec_cnt}, 0);
    check("rstwb_addr", {rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation of the completion counter
    for (int n = 0; n < 255; n++) issue(OP_NOP, 4'd0, 4'd0, 4'd0);
    check("cnt_255", exec_cnt, 255);
    issue(OP_NOP, 4'd0, 4'd0, 4'd0);
    check("cnt_sat_done", done_cnt, 1);
    check("cnt_sat", exec_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
